// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter: a start bit (0), WIDTH data bits MSB first,
// then a stop bit (1). Each bit is held for DIV clocks, timed by a bit-period counter.
module piso_serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] p_in,
  output logic             s_out,
  output logic             ready,
  output logic             done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             s_out_nxt, ready_nxt, done_nxt;
  logic             tick;

  // Outputs are computed for the state being entered, so they come straight off flops.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    s_out_nxt = s_out;
    ready_nxt = 1'b0;
    done_nxt  = 1'b0;
    tick      = (cnt == CNT_LAST);
    if (state != IDLE) cnt_nxt = tick ? '0 : cnt + CW'(1);
    case (state)
      IDLE: begin
        s_out_nxt = 1'b1;
        ready_nxt = 1'b1;
        if (load) begin
          shreg_nxt = p_in;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = START;
          s_out_nxt = 1'b0;
          ready_nxt = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_nxt = DATA;
          s_out_nxt = shreg[WIDTH-1];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx == IDX_LAST) begin
            state_nxt = STOP;
            s_out_nxt = 1'b1;
          end else begin
            idx_nxt   = idx + IW'(1);
            shreg_nxt = shreg << 1;
            s_out_nxt = shreg_nxt[WIDTH-1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
          s_out_nxt = 1'b1;
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        s_out_nxt = 1'b1;
        ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      s_out <= 1'b1;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
      s_out <= s_out_nxt;
      ready <= ready_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Scoreboard bench: a per-DUT frame-level model queues expected {s_out,ready,done}
// each cycle; a monitor pops and compares on the falling edge.
module tb_piso_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [7:0] p_in;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int D = (g == 0) ? 4 : 1;
    logic s_out, ready, done;
    logic [2:0] expq[$];
    logic       lv[$];
    logic [2:0] cur = 3'b110;
    bit         started = 0;
    int unsigned cyc = 0;

    piso_serial_tx #(.WIDTH(8), .DIV(D)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .p_in(p_in),
      .s_out(s_out), .ready(ready), .done(done)
    );

    // Reference: a frame is a list of line levels (start, data MSB first, stop),
    // each repeated D times; done marks the first idle cycle after a frame.
    always @(posedge clk) begin : model
      logic [2:0] nx;
      if (!rst_n) begin
        lv.delete();
        nx = 3'b110;
      end else if (cur[1] && load) begin
        lv.delete();
        repeat (D) lv.push_back(1'b0);
        for (int b = 7; b >= 0; b--) repeat (D) lv.push_back(p_in[b]);
        repeat (D) lv.push_back(1'b1);
        nx = {lv.pop_front(), 2'b00};
      end else if (lv.size() > 0) begin
        nx = {lv.pop_front(), 2'b00};
      end else if (!cur[1]) begin
        nx = 3'b111;
      end else begin
        nx = 3'b110;
      end
      cur = nx;
      expq.push_back(nx);
      started = 1;
    end

    always @(negedge clk) begin : monitor
      logic [2:0] e;
      if (started) begin
        cyc++;
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL div%0d cyc%0d scoreboard empty, got s/r/d=%b%b%b", D, cyc, s_out, ready, done);
        end else begin
          e = expq.pop_front();
          if ({s_out, ready, done} !== e)  begin
            fails++;
            $display("FAIL div%0d cyc%0d outputs s/r/d got %b%b%b exp %b%b%b",
                     D, cyc, s_out, ready, done, e[2], e[1], e[0]);
          end
        end
      end
    end
  end

  task automatic pulse(input logic [7:0] w);
    load = 1'b1;
    p_in = w;
    @(negedge clk);
    load = 1'b0;
    p_in = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    load  = 1'b1;
    p_in  = 8'h5A;
    idle(2);
    rst_n = 1'b1;
    load  = 1'b0;
    idle(3);

    // single frame, then busy-ignore with FF pulsed mid-frame
    pulse(8'hA5);
    idle(50);
    pulse(8'hA5);
    idle(12);
    pulse(8'hFF);
    idle(40);

    // back-to-back: load held, switch data on the done cycle
    load = 1'b1;
    p_in = 8'h00;
    n = 0;
    @(negedge clk);
    while (!u[0].done && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!u[0].done) begin
      fails++;
      $display("FAIL b2b_done got timeout after %0d cycles exp done pulse", n);
    end
    p_in = 8'hFF;
    @(negedge clk);
    load = 1'b0;
    idle(50);

    // reset during data bit 3, then a fresh frame
    pulse(8'hA5);
    idle(22);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    pulse(8'h3C);
    idle(50);

    pulse(8'h81);
    idle(50);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      load  = ($urandom_range(0, 5) == 0);
      p_in  = 8'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b1;
    load  = 1'b0;
    idle(60);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
